lift_call_queue: RTL and testbench

Front-end request stage for the lift controller. It synchronises asynchronous floor-call buttons, removes duplicate presses, and queues one level per call in arrival order. It presents the oldest call to the controller over a valid/ready handshake. A call stays "pending" until the controller reports that level as served, so a button held or re-pressed while its call is outstanding adds nothing to the queue.

---
 rtl/lift_pkg.sv | 15 +
 rtl/lift_call_fifo.sv | 56 +++++
 rtl/lift_call_queue.sv | 113 +++++++++++
 tb/tb_lift_call_queue.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
// Shared lift definitions: default floor count and level width, level type,
// and the door/motion state encodings used by the lift controller.
package lift_pkg;

   localparam int DEF_LEVELS = 5;
   localparam int DEF_LVL_W  = 3;

   typedef logic [DEF_LVL_W-1:0] lvl_t;

   localparam logic [2:0] ST_IDLE = 3'b000;
   localparam logic [2:0] ST_UP   = 3'b100;
   localparam logic [2:0] ST_DOWN = 3'b010;
   localparam logic [2:0] ST_OPEN = 3'b001;

endpackage

// File: rtl/lift_call_fifo.sv
// Circular call buffer; a push into a full buffer is accepted only when a pop
// frees the slot at the same edge.
module lift_call_fifo #(
   parameter int  W     = 3,
   parameter int  DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic [AW:0]  count,
   output logic         full,
   output logic         empty
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_pop;
   logic          do_push;

   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (!do_push && do_pop) begin
            count <= count - 1'b1;
         end
      end
   end

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

endmodule

// File: rtl/lift_call_queue.sv
// Floor-call front end: synchronises buttons, suppresses duplicate calls until
// served, and queues one level per call in arrival order.
module lift_call_queue
   import lift_pkg::*;
#(
   parameter int LEVELS = DEF_LEVELS,
   parameter int LVL_W  = DEF_LVL_W,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [LEVELS-1:0] call_btn,
   output logic              req_valid,
   output logic [LVL_W-1:0]  req_lvl,
   input  logic              req_ready,
   input  logic              served_valid,
   input  logic [LVL_W-1:0]  served_lvl,
   output logic [LEVELS-1:0] pend_map,
   output logic              full
);

   localparam int AW = $clog2(DEPTH);

   logic [LEVELS-1:0] s1, s2, s3;
   logic [LEVELS-1:0] rise;
   logic [LEVELS-1:0] cap;
   logic [LEVELS-1:0] pend;
   logic [LEVELS-1:0] serve_mask;
   logic [LEVELS-1:0] pend_kept;
   logic [LEVELS-1:0] new_cap;
   logic [LEVELS-1:0] push_mask;
   logic [LVL_W-1:0]  push_lvl;
   logic              push_ok;
   logic              pop;
   logic [LVL_W-1:0]  fifo_head;
   logic [AW:0]       count;
   logic              fifo_empty;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= call_btn;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

   // Out-of-range served levels match no bit and are ignored.
   always_comb begin
      serve_mask = '0;
      for (int i = 0; i < LEVELS; i++) begin
         if (served_valid && (served_lvl == LVL_W'(i))) begin
            serve_mask[i] = 1'b1;
         end
      end
   end

   always_comb begin
      push_mask = '0;
      push_lvl  = '0;
      for (int i = LEVELS - 1; i >= 0; i--) begin
         if (cap[i]) begin
            push_mask    = '0;
            push_mask[i] = 1'b1;
            push_lvl     = LVL_W'(i);
         end
      end
   end

   // Serve clears first, so an edge in the same cycle re-arms the floor.
   assign pend_kept = pend & ~serve_mask;
   assign new_cap   = rise & ~pend_kept;

   // req_valid/req_ready: the head transfers at a rising edge where both are
   // high; req_valid never depends on req_ready and req_lvl holds until taken.
   assign pop     = req_valid & req_ready;
   assign push_ok = (|cap) & (~full | pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap  <= '0;
         pend <= '0;
      end else begin
         cap  <= (cap & ~({LEVELS{push_ok}} & push_mask)) | new_cap;
         pend <= pend_kept | new_cap;
      end
   end

   lift_call_fifo #(
      .W     (LVL_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_ok),
      .push_data (push_lvl),
      .pop       (pop),
      .head      (fifo_head),
      .count     (count),
      .full      (full),
      .empty     (fifo_empty)
   );

   assign req_valid = (count != '0);
   assign req_lvl   = fifo_empty ? '0 : fifo_head;
   assign pend_map  = pend;

endmodule

// File: tb/tb_lift_call_queue.sv
// Self-checking bench for lift_call_queue: directed scenarios plus random
// traffic, all compared against a queue-based model of the call rules.
module tb_lift_call_queue;

   localparam int LEVELS = 5;
   localparam int LVL_W  = 3;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [LEVELS-1:0] call_btn;
   logic              req_valid;
   logic [LVL_W-1:0]  req_lvl;
   logic              req_ready;
   logic              served_valid;
   logic [LVL_W-1:0]  served_lvl;
   logic [LEVELS-1:0] pend_map;
   logic              full;

   int n_vec = 0;
   int n_err = 0;

   lift_call_queue #(
      .LEVELS (LEVELS),
      .LVL_W  (LVL_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .call_btn     (call_btn),
      .req_valid    (req_valid),
      .req_lvl      (req_lvl),
      .req_ready    (req_ready),
      .served_valid (served_valid),
      .served_lvl   (served_lvl),
      .pend_map     (pend_map),
      .full         (full)
   );

   always #5 clk = ~clk;

   wire [9:0] dut_out = {req_valid, req_lvl, pend_map, full};

   // Reference model: button sample history, capture/pending bits, call queue.
   logic [LEVELS-1:0] m_h0, m_h1, m_h2;
   logic [LEVELS-1:0] m_cap, m_pend;
   logic [LVL_W-1:0]  exp_q[$];

   task automatic model_clear();
      m_h0 = '0; m_h1 = '0; m_h2 = '0;
      m_cap = '0; m_pend = '0;
      exp_q.delete();
   endtask

   task automatic model_step();
      logic [LEVELS-1:0] rise;
      logic [LEVELS-1:0] kept;
      int lo;
      rise = m_h1 & ~m_h2;
      kept = m_pend;
      if (served_valid && served_lvl < LEVELS) kept[served_lvl] = 1'b0;
      lo = -1;
      for (int i = LEVELS - 1; i >= 0; i--) if (m_cap[i]) lo = i;
      if (exp_q.size() != 0 && req_ready) void'(exp_q.pop_front());
      if (lo >= 0 && exp_q.size() < DEPTH) begin
         exp_q.push_back(LVL_W'(lo));
         m_cap[lo] = 1'b0;
      end
      for (int i = 0; i < LEVELS; i++) begin
         if (rise[i] && !kept[i]) begin
            m_cap[i] = 1'b1;
            kept[i]  = 1'b1;
         end
      end
      m_pend = kept;
      m_h2 = m_h1; m_h1 = m_h0; m_h0 = call_btn;
   endtask

   function automatic logic [9:0] exp_out();
      logic [LVL_W-1:0] lvl;
      lvl = (exp_q.size() != 0) ? exp_q[0] : '0;
      return {exp_q.size() != 0, lvl, m_pend, exp_q.size() == DEPTH};
   endfunction

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic drain();
      call_btn = '0; req_ready = 1'b1; served_valid = 1'b0;
      for (int i = 0; i < 15; i++) begin
         served_valid = (i >= 10);
         served_lvl   = (i >= 10) ? LVL_W'(i - 10) : '0;
         cycle();
         n_vec++;
         if (dut_out !== exp_out()) begin
            n_err++;
            $display("FAIL drain i=%0d got %h expected %h", i, dut_out, exp_out());
         end
      end
      served_valid = 1'b0; req_ready = 1'b0; served_lvl = '0;
   endtask

   task automatic test_reset();
      reset = 1'b0; call_btn = '0; req_ready = 1'b0; served_valid = 1'b0; served_lvl = '0;
      model_clear();
      repeat (3) @(negedge clk);
      n_vec++;
      if (dut_out !== 10'd0) begin
         n_err++;
         $display("FAIL reset_outputs got %h expected 000", dut_out);
      end
      reset = 1'b1;
      for (int c = 1; c <= 2; c++) begin
         cycle();
         n_vec++;
         if (dut_out !== exp_out()) begin
            n_err++;
            $display("FAIL reset_idle c=%0d got %h expected %h", c, dut_out, exp_out());
         end
      end
   endtask

   task automatic test_single_call();
      logic [8:0] want;
      call_btn = 5'b01000; req_ready = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         cycle();
         n_vec++;
         if (dut_out !== exp_out()) begin
            n_err++;
            $display("FAIL single_model c=%0d got %h expected %h", c, dut_out, exp_out());
         end
         want = {c >= 4, (c >= 4) ? 3'd3 : 3'd0, (c >= 3) ? 5'b01000 : 5'b00000};
         n_vec++;
         if ({req_valid, req_lvl, pend_map} !== want) begin
            n_err++;
            $display("FAIL single_latency c=%0d got %h expected %h", c, {req_valid, req_lvl, pend_map}, want);
         end
         if (c == 5) call_btn = '0;
      end
      drain();
   endtask

   task automatic test_duplicate();
      call_btn = 5'b00100; req_ready = 1'b0;
      for (int c = 1; c <= 18; c++) begin
         cycle();
         n_vec++;
         if (dut_out !== exp_out()) begin
            n_err++;
            $display("FAIL dup_model c=%0d got %h expected %h", c, dut_out, exp_out());
         end
         case (c)
            3, 8: call_btn = '0;
            5:    call_btn = 5'b00100;
            12: begin
               n_vec++;
               if ({req_valid, req_lvl, pend_map} !== {1'b1, 3'd2, 5'b00100}) begin
                  n_err++;
                  $display("FAIL dup_queued got %h expected 1_2_04", {req_valid, req_lvl, pend_map});
               end
               req_ready = 1'b1;
            end
            13: begin
               n_vec++;
               if ({req_valid, pend_map} !== {1'b0, 5'b00100}) begin
                  n_err++;
                  $display("FAIL dup_one_entry got %h expected 04", {req_valid, pend_map});
               end
               req_ready = 1'b0; served_valid = 1'b1; served_lvl = 3'd2;
            end
            14: begin
               n_vec++;
               if (pend_map !== 5'b00000) begin
                  n_err++;
                  $display("FAIL dup_served got %b expected 00000", pend_map);
               end
               served_valid = 1'b0; call_btn = 5'b00100;
            end
            18: begin
               n_vec++;
               if ({req_valid, req_lvl} !== {1'b1, 3'd2}) begin
                  n_err++;
                  $display("FAIL dup_second_entry got %h expected 1_2", {req_valid, req_lvl});
               end
               call_btn = '0;
            end
            default: ;
         endcase
      end
      drain();
   endtask

   task automatic test_simultaneous();
      logic [LVL_W-1:0] seq [3];
      seq[0] = 3'd0; seq[1] = 3'd1; seq[2] = 3'd4;
      call_btn = 5'b10011; req_ready = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         cycle();
         n_vec++;
         if (dut_out !== exp_out()) begin
            n_err++;
            $display("FAIL simul_model c=%0d got %h expected %h", c, dut_out, exp_out());
         end
         if (c == 3) call_btn = '0;
         if (c >= 6 && c <= 8) begin
            n_vec++;
            if ({req_valid, req_lvl} !== {1'b1, seq[c-6]}) begin
               n_err++;
               $display("FAIL simul_order c=%0d got %h expected 1_%0d", c, {req_valid, req_lvl}, seq[c-6]);
            end
            req_ready = 1'b1;
         end
         if (c == 9) begin
            n_vec++;
            if (req_valid !== 1'b0) begin
               n_err++;
               $display("FAIL simul_empty got %b expected 0", req_valid);
            end
            req_ready = 1'b0;
         end
      end
      drain();
   endtask

   task automatic test_full();
      call_btn = 5'b11111; req_ready = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         cycle();
         n_vec++;
         if (dut_out !== exp_out()) begin
            n_err++;
            $display("FAIL full_model c=%0d got %h expected %h", c, dut_out, exp_out());
         end
         case (c)
            3: call_btn = '0;
            8: begin
               n_vec++;
               if ({full, req_lvl, pend_map} !== {1'b1, 3'd0, 5'b11111}) begin
                  n_err++;
                  $display("FAIL full_reached got %h expected 1_0_1f", {full, req_lvl, pend_map});
               end
               req_ready = 1'b1;
            end
            9, 10: begin
               n_vec++;
               if ({full, req_lvl} !== {1'b1, 3'd1}) begin
                  n_err++;
                  $display("FAIL full_pop_push c=%0d got %h expected 1_1", c, {full, req_lvl});
               end
               req_ready = (c == 10);
            end
            11, 12, 13: begin
               n_vec++;
               if (req_lvl !== LVL_W'(c - 9)) begin
                  n_err++;
                  $display("FAIL full_order c=%0d got %0d expected %0d", c, req_lvl, c - 9);
               end
            end
            14: begin
               n_vec++;
               if (req_valid !== 1'b0) begin
                  n_err++;
                  $display("FAIL full_drained got %b expected 0", req_valid);
               end
               req_ready = 1'b0;
            end
            default: ;
         endcase
      end
      drain();
   endtask

   task automatic test_serve_collide();
      call_btn = 5'b00010; req_ready = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         cycle();
         n_vec++;
         if (dut_out !== exp_out()) begin
            n_err++;
            $display("FAIL collide_model c=%0d got %h expected %h", c, dut_out, exp_out());
         end
         case (c)
            3: call_btn = '0;
            4: req_ready = 1'b1;
            5: begin
               req_ready = 1'b0; served_valid = 1'b1; served_lvl = 3'd6;
            end
            6: begin
               n_vec++;
               if ({req_valid, pend_map} !== {1'b0, 5'b00010}) begin
                  n_err++;
                  $display("FAIL collide_out_of_range got %h expected 02", {req_valid, pend_map});
               end
               served_valid = 1'b0; call_btn = 5'b00010;
            end
            8: begin
               served_valid = 1'b1; served_lvl = 3'd1;
            end
            9: begin
               n_vec++;
               if (pend_map[1] !== 1'b1) begin
                  n_err++;
                  $display("FAIL collide_rearm got %b expected 1", pend_map[1]);
               end
               served_valid = 1'b0; call_btn = '0;
            end
            10: begin
               n_vec++;
               if ({req_valid, req_lvl} !== {1'b1, 3'd1}) begin
                  n_err++;
                  $display("FAIL collide_requeue got %h expected 1_1", {req_valid, req_lvl});
               end
            end
            default: ;
         endcase
      end
      drain();
   endtask

   task automatic test_random();
      call_btn = '0;
      for (int c = 1; c <= 400; c++) begin
         if ($urandom_range(0, 3) == 0) call_btn[$urandom_range(0, LEVELS - 1)] ^= 1'b1;
         req_ready    = ($urandom_range(0, 2) == 0);
         served_valid = ($urandom_range(0, 3) == 0);
         served_lvl   = LVL_W'($urandom_range(0, 7));
         cycle();
         n_vec++;
         if (dut_out !== exp_out()) begin
            n_err++;
            $display("FAIL random c=%0d got %h expected %h", c, dut_out, exp_out());
         end
      end
      drain();
   endtask

   task automatic test_reset_mid();
      call_btn = 5'b01101; req_ready = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         cycle();
         n_vec++;
         if (dut_out !== exp_out()) begin
            n_err++;
            $display("FAIL rstmid_model c=%0d got %h expected %h", c, dut_out, exp_out());
         end
         if (c == 3) call_btn = '0;
      end
      n_vec++;
      if ({req_valid, full, pend_map} !== {1'b1, 1'b0, 5'b01101}) begin
         n_err++;
         $display("FAIL rstmid_loaded got %h expected 10_0d", {req_valid, full, pend_map});
      end
      #2 reset = 1'b0;
      model_clear();
      #1;
      n_vec++;
      if (dut_out !== 10'd0) begin
         n_err++;
         $display("FAIL rstmid_immediate got %h expected 000", dut_out);
      end
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (dut_out !== 10'd0) begin
         n_err++;
         $display("FAIL rstmid_held got %h expected 000", dut_out);
      end
      reset = 1'b1;
      test_single_call();
   endtask

   initial begin
      test_reset();
      test_single_call();
      test_duplicate();
      test_simultaneous();
      test_full();
      test_serve_collide();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
